addr_dec_resp_buf: RTL and testbench

ADDR_DEC_RESP_BUF -- requirements
Module: addr_dec_resp_buf

---
 rtl/tcdm_interco_pkg.sv | 13 +
 rtl/resp_fifo.sv | 74 +++++++
 rtl/addr_dec_resp_buf.sv | 101 ++++++++++
 tb/tb_addr_dec_resp_buf.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tcdm_interco_pkg.sv
// Shared sizing helpers for the TCDM interconnect blocks.
package tcdm_interco_pkg;

  // Bits needed to hold a count in the range 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 32'sd1) ? 32'sd1 : $clog2(max_val + 32'sd1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response FIFO with an optional combinational bypass when empty.
module resp_fifo
  import tcdm_interco_pkg::*;
#(
  parameter int Depth       = 4,
  parameter int DataWidth   = 32,
  parameter bit FallThrough = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o
);

  localparam int PW = ptr_width(Depth);
  localparam int CW = cnt_width(Depth);

  logic [DataWidth-1:0] mem_r [Depth];
  logic [PW-1:0]        wptr_r;
  logic [PW-1:0]        rptr_r;
  logic [CW-1:0]        count_r;
  logic                 empty_s;
  logic                 bypass_s;
  logic                 do_push_s;
  logic                 do_pop_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(Depth - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Head selection, bypass and push/pop qualification.
  always_comb begin
    empty_s  = (count_r == '0);
    bypass_s = FallThrough && empty_s && push_i;
    if (bypass_s) begin
      valid_o = 1'b1;
      data_o  = data_i;
    end else begin
      valid_o = !empty_s;
      data_o  = mem_r[rptr_r];
    end
    do_pop_s  = pop_i && !empty_s;
    // A bypassed response consumed in the same cycle never occupies a slot.
    do_push_s = push_i && !(bypass_s && pop_i);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) wptr_r <= ptr_next(wptr_r);
      else           wptr_r <= wptr_r;
      if (do_pop_s)  rptr_r <= ptr_next(rptr_r);
      else           rptr_r <= rptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/addr_dec_resp_buf.sv
// Address decoder towards NumSlave banks with fixed-latency in-order response buffering.
module addr_dec_resp_buf
  import tcdm_interco_pkg::*;
#(
  parameter int NumSlave       = 32,
  parameter int ReqDataWidth   = 32,
  parameter int RespDataWidth  = 32,
  parameter int RespLat        = 1,
  parameter int MaxOutstanding = 4,
  parameter bit FallThrough    = 1'b0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    req_i,
  input  logic [$clog2(NumSlave)-1:0]             add_i,
  input  logic [ReqDataWidth-1:0]                 data_i,
  output logic                                    gnt_o,
  output logic                                    rvld_o,
  input  logic                                    rready_i,
  output logic [RespDataWidth-1:0]                rdata_o,
  output logic [NumSlave-1:0]                     req_o,
  input  logic [NumSlave-1:0]                     gnt_i,
  output logic [NumSlave-1:0][ReqDataWidth-1:0]   data_o,
  input  logic [NumSlave-1:0][RespDataWidth-1:0]  rdata_i
);

  localparam int AW = $clog2(NumSlave);
  localparam int CW = cnt_width(MaxOutstanding);

  logic [CW-1:0]            cnt_r;
  logic                     room_s;
  logic                     pop_s;
  logic [RespLat-1:0]       pvld_r;
  logic [AW-1:0]            pbank_r [RespLat];
  logic                     rsp_vld_s;
  logic [RespDataWidth-1:0] rsp_data_s;

  assign data_o = {NumSlave{data_i}};

  // Bank decode; grants from unselected banks are ignored.
  always_comb begin
    room_s = (cnt_r < CW'(MaxOutstanding));
    req_o  = '0;
    gnt_o  = 1'b0;
    for (int i = 0; i < NumSlave; i++) begin
      if (add_i == AW'(i)) begin
        req_o[i] = req_i && room_s;
        gnt_o    = req_i && room_s && gnt_i[i];
      end else begin
        req_o[i] = 1'b0;
      end
    end
  end

  assign pop_s      = rvld_o && rready_i;
  assign rsp_vld_s  = pvld_r[RespLat-1];
  assign rsp_data_s = rdata_i[pbank_r[RespLat-1]];

  // Outstanding counter: granted but not yet consumed by the master.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else begin
      case ({gnt_o, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Latency-matching pipeline tracking which bank answers in which cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pvld_r <= '0;
      for (int k = 0; k < RespLat; k++) pbank_r[k] <= '0;
    end else begin
      pvld_r[0]  <= gnt_o;
      pbank_r[0] <= add_i;
      for (int k = RespLat - 1; k > 0; k--) begin
        pvld_r[k]  <= pvld_r[k-1];
        pbank_r[k] <= pbank_r[k-1];
      end
    end
  end

  resp_fifo #(
    .Depth      (MaxOutstanding),
    .DataWidth  (RespDataWidth),
    .FallThrough(FallThrough)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (rsp_vld_s),
    .data_i (rsp_data_s),
    .pop_i  (rready_i),
    .valid_o(rvld_o),
    .data_o (rdata_o)
  );

endmodule

// File: tb/tb_addr_dec_resp_buf.sv
// Directed bench: one buffered instance (Max=4) and one fall-through instance (Max=2) on shared stimulus.
module tb_addr_dec_resp_buf;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req;
  logic [AW-1:0]          add;
  logic [DW-1:0]          wdata;
  logic                   rready;
  logic [NS-1:0]          gnt_in;
  logic [NS-1:0][DW-1:0]  rdata_in;

  logic                   a_gnt, a_rvld, b_gnt, b_rvld;
  logic [DW-1:0]          a_rdata, b_rdata;
  logic [NS-1:0]          a_req, b_req;
  logic [NS-1:0][DW-1:0]  a_wdata, b_wdata;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  addr_dec_resp_buf #(
    .NumSlave(NS), .ReqDataWidth(DW), .RespDataWidth(DW),
    .RespLat(1), .MaxOutstanding(4), .FallThrough(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .data_i(wdata),
    .gnt_o(a_gnt), .rvld_o(a_rvld), .rready_i(rready), .rdata_o(a_rdata),
    .req_o(a_req), .gnt_i(gnt_in), .data_o(a_wdata), .rdata_i(rdata_in)
  );

  addr_dec_resp_buf #(
    .NumSlave(NS), .ReqDataWidth(DW), .RespDataWidth(DW),
    .RespLat(1), .MaxOutstanding(2), .FallThrough(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .data_i(wdata),
    .gnt_o(b_gnt), .rvld_o(b_rvld), .rready_i(rready), .rdata_o(b_rdata),
    .req_o(b_req), .gnt_i(gnt_in), .data_o(b_wdata), .rdata_i(rdata_in)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req    = 1'b0;
    add    = '0;
    gnt_in = '0;
    rready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    wdata       = 32'h0000_CAFE;
    rdata_in[0] = 32'h0000_0010;
    rdata_in[1] = 32'h0000_0011;
    rdata_in[2] = 32'h0000_00A5;
    rdata_in[3] = 32'h0000_0013;

    // Reset state
    do_reset();
    settle();
    check_eq("rst_rvld_a", 64'(a_rvld), 64'd0);
    check_eq("rst_gnt_a", 64'(a_gnt), 64'd0);
    check_eq("rst_req_a", 64'(a_req), 64'd0);
    check_eq("rst_cnt_a", 64'(dut_a.cnt_r), 64'd0);
    check_eq("rst_rvld_b", 64'(b_rvld), 64'd0);
    check_eq("wdata_bcast", 64'(a_wdata[3]), 64'h0000_CAFE);

    // Single grant to bank 2: rvld two cycles after grant without fall-through
    req = 1'b1; add = 2'd2; gnt_in = 4'b0100; settle();
    check_eq("dec_req_b2", 64'(a_req), 64'b0100);
    check_eq("dec_gnt_b2", 64'(a_gnt), 64'd1);
    tick(); req = 1'b0; gnt_in = '0; settle();
    check_eq("ft0_not_early", 64'(a_rvld), 64'd0);
    check_eq("ft1_arrive_vld", 64'(b_rvld), 64'd1);
    check_eq("ft1_arrive_data", 64'(b_rdata), 64'hA5);
    tick(); settle();
    check_eq("ft0_lat_vld", 64'(a_rvld), 64'd1);
    check_eq("ft0_lat_data", 64'(a_rdata), 64'hA5);
    rready = 1'b1; tick(); rready = 1'b0; settle();
    check_eq("pop_rvld", 64'(a_rvld), 64'd0);
    check_eq("pop_cnt", 64'(dut_a.cnt_r), 64'd0);

    // Back-to-back grants to banks 0,3,1 with all gnt_i bits set
    do_reset();
    rready = 1'b1; req = 1'b1; add = 2'd0; gnt_in = 4'b1111; settle();
    check_eq("b2b_req0", 64'(a_req), 64'b0001);
    check_eq("b2b_gnt0", 64'(a_gnt), 64'd1);
    tick(); add = 2'd3; settle();
    check_eq("one_grant_cnt", 64'(dut_a.cnt_r), 64'd1);
    check_eq("b2b_a_wait", 64'(a_rvld), 64'd0);
    check_eq("ft1_vld0", 64'(b_rvld), 64'd1);
    check_eq("ft1_data0", 64'(b_rdata), 64'h10);
    check_eq("ft1_fifo_empty0", 64'(dut_b.u_resp_fifo.count_r), 64'd0);
    tick(); add = 2'd1; settle();
    check_eq("b2b_a_vld0", 64'(a_rvld), 64'd1);
    check_eq("b2b_a_data0", 64'(a_rdata), 64'h10);
    check_eq("ft1_data3", 64'(b_rdata), 64'h13);
    tick(); req = 1'b0; settle();
    check_eq("b2b_a_data3", 64'(a_rdata), 64'h13);
    check_eq("ft1_data1", 64'(b_rdata), 64'h11);
    check_eq("ft1_fifo_empty1", 64'(dut_b.u_resp_fifo.count_r), 64'd0);
    tick(); settle();
    check_eq("b2b_a_vld1", 64'(a_rvld), 64'd1);
    check_eq("b2b_a_data1", 64'(a_rdata), 64'h11);
    check_eq("ft1_drained", 64'(b_rvld), 64'd0);
    tick(); settle();
    check_eq("b2b_a_drained", 64'(a_rvld), 64'd0);
    check_eq("b2b_cnt_end", 64'(dut_a.cnt_r), 64'd0);

    // Outstanding limit on the Max=2 instance
    do_reset();
    req = 1'b1; add = 2'd1; gnt_in = 4'b1111; settle();
    check_eq("lim_gnt_first", 64'(b_gnt), 64'd1);
    tick(); tick(); settle();
    check_eq("lim_req_blk", 64'(b_req), 64'd0);
    check_eq("lim_gnt_blk", 64'(b_gnt), 64'd0);
    tick(); settle();
    check_eq("lim_req_hold", 64'(b_req), 64'd0);
    rready = 1'b1; settle();
    check_eq("lim_pop_vld", 64'(b_rvld), 64'd1);
    check_eq("lim_pop_data", 64'(b_rdata), 64'h11);
    check_eq("lim_same_cyc", 64'(b_req), 64'd0);
    tick(); rready = 1'b0; settle();
    check_eq("lim_req_again", 64'(b_req), 64'b0010);
    check_eq("lim_gnt_again", 64'(b_gnt), 64'd1);

    // Reset with three responses in flight
    do_reset();
    req = 1'b1; add = 2'd0; gnt_in = 4'b1111; settle();
    tick(); add = 2'd1;
    tick(); add = 2'd2;
    tick(); req = 1'b0; settle();
    check_eq("inflight_cnt", 64'(dut_a.cnt_r), 64'd3);
    check_eq("inflight_vld", 64'(a_rvld), 64'd1);
    rst = 1'b1; tick(); settle();
    check_eq("mid_rst_vld", 64'(a_rvld), 64'd0);
    check_eq("mid_rst_cnt", 64'(dut_a.cnt_r), 64'd0);
    rst = 1'b0; rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check_eq("late_discard", 64'(a_rvld), 64'd0);
    end
    check_eq("post_rst_cnt", 64'(dut_a.cnt_r), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
